// File: rtl/ps2_key_pkg.sv
// Shared constants, state encodings and scancode tables
// for the PS/2 key event decoder.
package ps2_key_pkg;

  localparam logic [2:0] K_CHAR  = 3'd0;
  localparam logic [2:0] K_LEFT  = 3'd1;
  localparam logic [2:0] K_RIGHT = 3'd2;
  localparam logic [2:0] K_UP    = 3'd3;
  localparam logic [2:0] K_DOWN  = 3'd4;
  localparam logic [2:0] K_ENTER = 3'd5;
  localparam logic [2:0] K_BACK  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  localparam logic [7:0] B_EXT    = 8'hE0;
  localparam logic [7:0] B_BRK    = 8'hF0;
  localparam logic [7:0] B_LSHIFT = 8'h12;
  localparam logic [7:0] B_RSHIFT = 8'h59;

  function automatic logic is_ignored(
    input logic [7:0] code
  );
    return code inside {8'hAA, 8'hFA, 8'hEE,
                        8'hFE, 8'h00, 8'hFF};
  endfunction

  function automatic logic [6:0] scan_to_ascii(
    input logic [7:0] code
  );
    logic [7:0] r;
    case (code)
      8'h1C: r = "a";  8'h32: r = "b";
      8'h21: r = "c";  8'h23: r = "d";
      8'h24: r = "e";  8'h2B: r = "f";
      8'h34: r = "g";  8'h33: r = "h";
      8'h43: r = "i";  8'h3B: r = "j";
      8'h42: r = "k";  8'h4B: r = "l";
      8'h3A: r = "m";  8'h31: r = "n";
      8'h44: r = "o";  8'h4D: r = "p";
      8'h15: r = "q";  8'h2D: r = "r";
      8'h1B: r = "s";  8'h2C: r = "t";
      8'h3C: r = "u";  8'h2A: r = "v";
      8'h1D: r = "w";  8'h22: r = "x";
      8'h35: r = "y";  8'h1A: r = "z";
      8'h16: r = "1";  8'h1E: r = "2";
      8'h26: r = "3";  8'h25: r = "4";
      8'h2E: r = "5";  8'h36: r = "6";
      8'h3D: r = "7";  8'h3E: r = "8";
      8'h46: r = "9";  8'h45: r = "0";
      8'h29: r = " ";  8'h0E: r = 8'h60;
      8'h4E: r = "-";  8'h55: r = "=";
      8'h54: r = "[";  8'h5B: r = "]";
      8'h4C: r = ";";  8'h52: r = "'";
      8'h41: r = ",";  8'h49: r = ".";
      8'h4A: r = "/";  8'h5D: r = "\\";
      default: r = 8'h00;
    endcase
    return r[6:0];
  endfunction

  function automatic logic [6:0] scan_to_ascii_shift(
    input logic [7:0] code
  );
    logic [7:0] b;
    logic [7:0] r;
    b = {1'b0, scan_to_ascii(code)};
    if (b >= "a" && b <= "z") begin
      r = b - 8'd32;
    end else begin
      case (b)
        "1": r = "!";  "2": r = "@";
        "3": r = "#";  "4": r = "$";
        "5": r = "%";  "6": r = "^";
        "7": r = "&";  "8": r = "*";
        "9": r = "(";  "0": r = ")";
        8'h60: r = "~";  "-": r = "_";
        "=": r = "+";  "[": r = "{";
        "]": r = "}";  ";": r = ":";
        "'": r = "\""; ",": r = "<";
        ".": r = ">";  "/": r = "?";
        "\\": r = "|";
        default: r = b;
      endcase
    end
    return r[6:0];
  endfunction

endpackage

// File: rtl/ps2_key_event_decoder_fifo.sv
// Synchronous event FIFO carrying {kind, char};
// the head reads as zero while the FIFO is empty.
module event_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [9:0] din,
  output logic       full,
  output logic       empty,
  output logic [9:0] dout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot for a full-FIFO push
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset && do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 byte stream to key events: prefix FSM, shift
// tracking, repeat filter, decode register and FIFO.
module ps2_key_event_decoder
  import ps2_key_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter bit REPEAT_FILTER = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [2:0] ev_kind,
  output logic [6:0] ev_char,
  output logic       shift_held,
  output logic       overflow
);
  state_t     state;
  state_t     state_nx;
  logic       lshift;
  logic       rshift;
  logic       last_valid;
  logic [8:0] last_make;
  logic       dec_valid;
  logic [9:0] dec_ev;
  logic       ext;
  logic       brk;
  logic       key_hit;
  logic       is_shift;
  logic       match;
  logic       mapped;
  logic       emit;
  logic [2:0] mk_kind;
  logic [6:0] mk_char;
  logic [6:0] ch;
  logic       full;
  logic       empty;
  logic       pop;

  assign ext = (state == S_EXT) || (state == S_EXT_BRK);
  assign brk = (state == S_BRK) || (state == S_EXT_BRK);
  assign key_hit = scan_valid && !is_ignored(scan_code)
                && scan_code != B_EXT && scan_code != B_BRK;
  assign is_shift = (scan_code == B_LSHIFT)
                 || (scan_code == B_RSHIFT);
  assign match = last_valid && (last_make == {ext, scan_code});
  assign ch = shift_held ? scan_to_ascii_shift(scan_code)
                         : scan_to_ascii(scan_code);
  assign emit = key_hit && !brk && !is_shift && mapped
             && !(REPEAT_FILTER && match);
  assign shift_held = lshift | rshift;
  assign pop = ev_valid && ev_ready;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mk_kind  = K_CHAR;
    mk_char  = '0;
    mapped   = 1'b0;
    if (scan_valid && !is_ignored(scan_code)) begin
      unique case (1'b1)
        (scan_code == B_EXT): state_nx = S_EXT;
        (scan_code == B_BRK):
          state_nx = ext ? S_EXT_BRK : S_BRK;
        default: state_nx = S_IDLE;
      endcase
    end
    if (ext) begin
      mapped = 1'b1;
      case (scan_code)
        8'h75:   mk_kind = K_UP;
        8'h72:   mk_kind = K_DOWN;
        8'h6B:   mk_kind = K_LEFT;
        8'h74:   mk_kind = K_RIGHT;
        8'h5A:   mk_kind = K_ENTER;
        default: mapped  = 1'b0;
      endcase
    end else begin
      mapped = 1'b1;
      case (scan_code)
        8'h5A: mk_kind = K_ENTER;
        8'h66: mk_kind = K_BACK;
        default: begin
          mk_char = ch;
          mapped  = (ch != '0);
        end
      endcase
    end
  end

  // E0-prefixed shift codes are fake shifts and leave state alone
  always_ff @(posedge clk) begin
    if (!reset) begin
      lshift <= 1'b0;
      rshift <= 1'b0;
    end else if (key_hit && !ext) begin
      if (scan_code == B_LSHIFT) lshift <= !brk;
      if (scan_code == B_RSHIFT) rshift <= !brk;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_valid <= 1'b0;
      last_make  <= '0;
    end else if (key_hit && !is_shift) begin
      if (brk) begin
        if (match) last_valid <= 1'b0;
      end else if (emit) begin
        last_make  <= {ext, scan_code};
        last_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dec_valid <= 1'b0;
      dec_ev    <= '0;
    end else begin
      dec_valid <= emit;
      dec_ev    <= {mk_kind, mk_char};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)                          overflow <= 1'b0;
    else if (dec_valid && full && !pop)  overflow <= 1'b1;
  end

  event_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (dec_valid),
    .pop  (pop),
    .din  (dec_ev),
    .full (full),
    .empty(empty),
    .dout ({ev_kind, ev_char})
  );

  assign ev_valid = !empty;
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: directed scenarios
// plus a random byte stream against a table-driven model.
module tb_ps2_key_event_decoder;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       ev_ready = 1'b0;
  logic       ev_valid, shift_held, overflow;
  logic [2:0] ev_kind;
  logic [6:0] ev_char;
  logic       v0, s0, o0;
  logic [2:0] k0;
  logic [6:0] c0;

  int total = 0;
  int bad = 0;
  logic [9:0] got[$];
  logic [9:0] got0[$];
  logic [9:0] exp[$];

  logic [7:0] kc [48] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
    8'h35, 8'h1A, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46, 8'h45, 8'h29, 8'h0E, 8'h4E, 8'h55,
    8'h54, 8'h5B, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h5D};
  string lo = "abcdefghijklmnopqrstuvwxyz1234567890 `-=[];',./\\";
  string hi = "ABCDEFGHIJKLMNOPQRSTUVWXYZ!@#$%^&*() ~_+{}:\"<>?|";

  logic m_ext, m_brk, m_ls, m_rs, m_lv;
  logic [8:0] m_last;

  ps2_key_event_decoder #(.FIFO_DEPTH(4), .REPEAT_FILTER(1'b1)) dut (
    .clk(clk), .reset(reset), .scan_valid(scan_valid),
    .scan_code(scan_code), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_kind(ev_kind), .ev_char(ev_char), .shift_held(shift_held),
    .overflow(overflow));

  ps2_key_event_decoder #(.FIFO_DEPTH(4), .REPEAT_FILTER(1'b0)) dut0 (
    .clk(clk), .reset(reset), .scan_valid(scan_valid),
    .scan_code(scan_code), .ev_valid(v0), .ev_ready(ev_ready),
    .ev_kind(k0), .ev_char(c0), .shift_held(s0), .overflow(o0));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && ev_valid && ev_ready) got.push_back({ev_kind, ev_char});
    if (reset && v0 && ev_ready) got0.push_back({k0, c0});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    scan_valid = 1'b1;
    scan_code = b;
    tick();
    scan_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_ls = 0; m_rs = 0; m_lv = 0; m_last = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    model_reset();
  endtask

  function automatic logic [6:0] lookup(input logic [7:0] b, input logic sh);
    for (int i = 0; i < 48; i++)
      if (kc[i] == b) return sh ? 7'(hi[i]) : 7'(lo[i]);
    return 7'd0;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int kind;
    logic [6:0] c;
    logic [8:0] key;
    logic hit;
    if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) return;
    if (b == 8'hE0) begin m_ext = 1; m_brk = 0; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    key = {m_ext, b};
    hit = m_lv && (m_last == key);
    if (b == 8'h12 || b == 8'h59) begin
      if (!m_ext) begin
        if (b == 8'h12) m_ls = !m_brk;
        else m_rs = !m_brk;
      end
    end else if (m_brk) begin
      if (hit) m_lv = 0;
    end else begin
      kind = -1;
      c = 7'd0;
      if (m_ext) begin
        case (b)
          8'h75: kind = 3;
          8'h72: kind = 4;
          8'h6B: kind = 1;
          8'h74: kind = 2;
          8'h5A: kind = 5;
          default: kind = -1;
        endcase
      end else if (b == 8'h5A) kind = 5;
      else if (b == 8'h66) kind = 6;
      else begin
        c = lookup(b, m_ls | m_rs);
        if (c != 0) kind = 0;
      end
      if (kind >= 0 && !hit) begin
        exp.push_back({3'(kind), c});
        m_last = key;
        m_lv = 1;
      end
    end
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", ev_valid); end
    total++; if (ev_kind !== 3'd0) begin bad++; $display("FAIL reset_kind got=%0h want=0", ev_kind); end
    total++; if (ev_char !== 7'd0) begin bad++; $display("FAIL reset_char got=%0h want=0", ev_char); end
    total++; if (shift_held !== 1'b0) begin bad++; $display("FAIL reset_shift got=%0h want=0", shift_held); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0h want=0", overflow); end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_char_timing();
    int base;
    do_reset();
    ev_ready = 1'b1;
    base = got.size();
    put(8'h1C);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL char_early got=%0h want=0", ev_valid); end
    tick();
    total++; if (ev_valid !== 1'b1) begin bad++; $display("FAIL char_valid got=%0h want=1", ev_valid); end
    total++; if ({ev_kind, ev_char} !== {3'd0, 7'h61}) begin bad++; $display("FAIL char_head got=%0h want=%0h", {ev_kind, ev_char}, {3'd0, 7'h61}); end
    tick();
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL char_oneshot got=%0h want=0", ev_valid); end
    put(8'hF0);
    put(8'h1C);
    repeat (6) tick();
    total++; if (got.size() - base != 1) begin bad++; $display("FAIL char_count got=%0d want=1", got.size() - base); end
  endtask

  task automatic test_shift();
    int base;
    do_reset();
    ev_ready = 1'b1;
    base = got.size();
    put(8'h12);
    total++; if (shift_held !== 1'b1) begin bad++; $display("FAIL shift_on got=%0h want=1", shift_held); end
    put(8'h1E); put(8'hF0); put(8'h1E);
    total++; if (shift_held !== 1'b1) begin bad++; $display("FAIL shift_hold got=%0h want=1", shift_held); end
    put(8'hF0); put(8'h12);
    total++; if (shift_held !== 1'b0) begin bad++; $display("FAIL shift_off got=%0h want=0", shift_held); end
    put(8'h1E);
    repeat (6) tick();
    total++;
    if (got.size() - base != 2) begin
      bad++; $display("FAIL shift_count got=%0d want=2", got.size() - base);
    end else begin
      if (got[base] !== {3'd0, 7'h40}) begin bad++; $display("FAIL shift_ev0 got=%0h want=%0h", got[base], {3'd0, 7'h40}); end
      total++;
      if (got[base+1] !== {3'd0, 7'h32}) begin bad++; $display("FAIL shift_ev1 got=%0h want=%0h", got[base+1], {3'd0, 7'h32}); end
    end
  endtask

  task automatic test_ext();
    int base;
    do_reset();
    ev_ready = 1'b1;
    base = got.size();
    put(8'hE0); put(8'h75);
    put(8'hE0); put(8'hF0); put(8'h75);
    put(8'h75);
    put(8'h1C);
    repeat (6) tick();
    total++;
    if (got.size() - base != 2) begin
      bad++; $display("FAIL ext_count got=%0d want=2", got.size() - base);
    end else begin
      if (got[base] !== {3'd3, 7'h00}) begin bad++; $display("FAIL ext_up got=%0h want=%0h", got[base], {3'd3, 7'h00}); end
      total++;
      if (got[base+1] !== {3'd0, 7'h61}) begin bad++; $display("FAIL ext_idle got=%0h want=%0h", got[base+1], {3'd0, 7'h61}); end
    end
  endtask

  task automatic test_repeat();
    int base, base0;
    do_reset();
    ev_ready = 1'b1;
    base = got.size();
    base0 = got0.size();
    put(8'h1C); put(8'h1C); put(8'h1C);
    put(8'hF0); put(8'h1C); put(8'h1C);
    repeat (8) tick();
    total++; if (got.size() - base != 2) begin bad++; $display("FAIL rep_filter got=%0d want=2", got.size() - base); end
    total++; if (got0.size() - base0 != 4) begin bad++; $display("FAIL rep_pass got=%0d want=4", got0.size() - base0); end
  endtask

  task automatic test_overflow();
    logic [6:0] want [4] = '{7'h61, 7'h62, 7'h63, 7'h64};
    do_reset();
    ev_ready = 1'b0;
    put(8'h1C); put(8'h32); put(8'h21); put(8'h23);
    put(8'h24);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0h want=0", overflow); end
    tick();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0h want=1", overflow); end
    put(8'h2B);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ev_valid !== 1'b1 || ev_char !== 7'h61) begin
        bad++; $display("FAIL ovf_stall got=%0h/%0h want=1/61", ev_valid, ev_char);
      end
    end
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ev_valid !== 1'b1 || {ev_kind, ev_char} !== {3'd0, want[i]}) begin
        bad++; $display("FAIL ovf_drain%0d got=%0h/%0h want=1/%0h", i, ev_valid, {ev_kind, ev_char}, {3'd0, want[i]});
      end
      tick();
    end
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%0h want=0", ev_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0h want=1", overflow); end
  endtask

  task automatic test_reset_mid();
    ev_ready = 1'b1;
    put(8'hE0); put(8'hF0);
    reset = 1'b0;
    tick();
    total++;
    if ({ev_valid, ev_kind, ev_char, shift_held, overflow} !== '0) begin
      bad++; $display("FAIL mid_zero got=%0h want=0", {ev_valid, ev_kind, ev_char, shift_held, overflow});
    end
    tick();
    reset = 1'b1;
    model_reset();
    put(8'h66);
    tick();
    total++; if (ev_valid !== 1'b1) begin bad++; $display("FAIL mid_valid got=%0h want=1", ev_valid); end
    total++; if ({ev_kind, ev_char} !== {3'd6, 7'h00}) begin bad++; $display("FAIL mid_back got=%0h want=%0h", {ev_kind, ev_char}, {3'd6, 7'h00}); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_ovf got=%0h want=0", overflow); end
    repeat (3) tick();
  endtask

  task automatic test_full_pop();
    int base;
    do_reset();
    ev_ready = 1'b0;
    base = got.size();
    put(8'h1C); put(8'h32); put(8'h21); put(8'h23);
    put(8'h24);
    ev_ready = 1'b1;
    repeat (10) tick();
    total++;
    if (got.size() - base != 5) begin
      bad++; $display("FAIL fullpop_count got=%0d want=5", got.size() - base);
    end else begin
      if (got[base+4] !== {3'd0, 7'h65}) begin bad++; $display("FAIL fullpop_last got=%0h want=%0h", got[base+4], {3'd0, 7'h65}); end
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_ovf got=%0h want=0", overflow); end
  endtask

  task automatic test_random();
    logic [7:0] pool [24] = '{
      8'h1C, 8'h32, 8'h1E, 8'h16, 8'h45, 8'h29, 8'h4E, 8'h5A,
      8'h66, 8'h12, 8'h59, 8'hE0, 8'hF0, 8'hF0, 8'h75, 8'h6B,
      8'hAA, 8'hFA, 8'h00, 8'hFF, 8'h0E, 8'h52, 8'h5D, 8'h01};
    int base, n, lim;
    logic [7:0] b;
    do_reset();
    base = got.size();
    exp.delete();
    for (int i = 0; i < 400; i++) begin
      lim = 0;
      while (exp.size() - (got.size() - base) >= 3 && lim < 40) begin
        ev_ready = 1'b1;
        tick();
        lim++;
      end
      ev_ready = 1'($urandom_range(0, 1));
      b = pool[$urandom_range(0, 23)];
      model_byte(b);
      put(b);
      if ($urandom_range(0, 3) == 0) tick();
    end
    ev_ready = 1'b1;
    lim = 0;
    while (got.size() - base < exp.size() && lim < 100) begin
      tick();
      lim++;
    end
    repeat (4) tick();
    n = got.size() - base;
    total++; if (n != exp.size()) begin bad++; $display("FAIL rnd_count got=%0d want=%0d", n, exp.size()); end
    if (n > exp.size()) n = exp.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (got[base+i] !== exp[i]) begin
        bad++; $display("FAIL rnd_ev%0d got=%0h want=%0h", i, got[base+i], exp[i]);
      end
    end
    total++; if (shift_held !== (m_ls | m_rs)) begin bad++; $display("FAIL rnd_shift got=%0h want=%0h", shift_held, m_ls | m_rs); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rnd_ovf got=%0h want=0", overflow); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_char_timing();
    test_shift();
    test_ext();
    test_repeat();
    test_overflow();
    test_reset_mid();
    test_full_pop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_key_event_decoder.md
# ps2_key_event_decoder

Converts the raw PS/2 byte stream from the keyboard driver into discrete key events for the text console's cursor/character-RAM logic. It handles the E0/F0 prefix protocol, shift state and typematic-repeat suppression, and buffers events in a small FIFO behind a valid/ready handshake. The block replaces the ad-hoc press-delay counter and the combinational scancode chart. It sits between the PS/2 receiver (upstream) and the cursor/character-write logic (downstream).

## Interface
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2
- REPEAT_FILTER, 1, 1 = drop a make code identical to the last unreleased make; 0 = pass repeats

- clk  in  1  75 MHz pixel clock, shared with the display pipeline
- reset  in  1  synchronous, active-low; all state is cleared on a rising clk edge while low
- scan_valid  in  1  one-cycle strobe: scan_code holds a newly received byte
- scan_code  in  8  received PS/2 byte
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts the head; a pop occurs when ev_valid && ev_ready
- ev_kind  out  3  0 CHAR, 1 LEFT, 2 RIGHT, 3 UP, 4 DOWN, 5 ENTER, 6 BACK
- ev_char  out  7  ASCII code; meaningful only when ev_kind = CHAR, otherwise 0
- shift_held  out  1  left shift OR right shift currently down
- overflow  out  1  sticky: an event was dropped because the FIFO was full

## Operation
- Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
  - Byte E0 in any state goes to EXT.
  - Byte F0 goes IDLE→BRK, EXT→EXT_BRK, and leaves BRK/EXT_BRK unchanged.
  - Any other byte is a key code and is decoded using the current state, then the FSM returns to IDLE.
- The bytes AA, FA, EE, FE, 00 and FF are ignored in every state, and the state does not change.
- Shift:
  - Make 12 sets lshift; break 12 clears it.
  - Make 59 sets rshift; break 59 clears it.
  - Shift codes produce no event, and the E0-prefixed forms are ignored.
- Break codes produce no event. A break clears last_make if the code (including the ext bit) matches.
- Make decode:
  - Extended: 75 UP, 72 DOWN, 6B LEFT, 74 RIGHT, 5A ENTER.
  - Non-extended: 5A ENTER, 66 BACK, and printable keys map to CHAR through the shared US table.
  - Shift changes letters to upper case, digits to !@#$%^&*(), and punctuation to its shifted symbol.
  - Unmapped codes, including non-extended keypad 75/72/6B/74, produce no event.
- Repeat filter (REPEAT_FILTER=1):
  - last_make is a 9-bit value {ext, code} with a valid flag.
  - A make equal to a valid last_make is dropped.
  - Any other decoded make is emitted and becomes last_make. Shift keys do not update last_make.
- FIFO:
  - Every decoded event is pushed.
  - If the FIFO is full and no pop happens in that cycle, the event is dropped and overflow is set.
  - If the FIFO is full and a pop happens in the same cycle, the push is accepted.
  - overflow clears only on reset.

## Timing
- Values during and after reset: ev_valid=0, ev_kind=0, ev_char=0, shift_held=0, overflow=0, FSM=IDLE, last_make invalid, FIFO empty.
- Decode register: scan_valid at edge N registers the event at N+1, and it is written into the FIFO the same cycle.
- ev_valid rises at N+2 when the FIFO was empty. The head outputs are registered, with no combinational path from scan_code.
- shift_held updates at N+1.
- Throughput is one byte per cycle. Back-to-back scan_valid is legal.
- ev_kind and ev_char stay stable while ev_valid && !ev_ready.
- If reset is asserted mid-sequence (for example after E0 F0), a following code is treated as a plain make from IDLE.
- Count arithmetic is FIFO_DEPTH+1 states wide. Pointers wrap modulo FIFO_DEPTH.

## Structure
- Package ps2_key_pkg holds:
  - the ev_kind constants;
  - the FSM state encodings;
  - the prefix/ignore byte constants;
  - the functions scan_to_ascii(code) and scan_to_ascii_shift(code), which return 7 bits with 0 meaning unmapped.
- Sub-module event_fifo: synchronous FIFO, 10-bit payload {kind, char}, parameter FIFO_DEPTH, ports clk/reset/push/pop/full/empty/dout.
- Top level: prefix FSM, shift/last_make registers, decode register, and the event_fifo instance.

## Test plan
- Bytes 1C, F0 1C with ev_ready=1: one event, CHAR 0x61, ev_valid high for exactly one cycle, first seen 2 cycles after the 1C strobe.
- Bytes 12, 1E, F0 1E, F0 12, 1E: CHAR 0x40 then CHAR 0x32; shift_held is 1 between the 12 strobe+1 and the F0 12 release.
- Bytes E0 75, E0 F0 75, 75: one UP event only; the non-extended 75 is silent. The FSM is IDLE afterwards.
- REPEAT_FILTER=1, bytes 1C 1C 1C F0 1C 1C: exactly two CHAR 0x61 events. With REPEAT_FILTER=0 the same stream gives four.
- ev_ready=0, six distinct makes at FIFO_DEPTH=4: four buffered, overflow=1 after the fifth. Raising ev_ready then drains 4 events in order, one per cycle.
- reset held low after E0 F0 and released, then 66: BACK event emitted, overflow=0, all outputs zero during reset.
